// File: rtl/car_pkg.sv
// Shared constants for the turn-signal/hazard car design.
// Default sizes, debounce length and key polarity used by conditioner, nsl and ol.
package car_pkg;

    localparam int NUM_SW          = 10;
    localparam int NUM_KEY         = 2;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 200000;  // 20 ms at 10 MHz

    // Keys pull the pin low when pressed
    localparam logic KEY_PRESSED = 1'b0;

    // Width of a counter that can hold 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/car_debounce_bit.sv
// Single-bit synchroniser + debouncer with registered rise/fall pulses.
// Ports: clock, reset (sync, active-high), raw (async pin) -> clean level, rise, fall.
module debounce_bit #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 200000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int CW = car_pkg::cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, fall_q;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Any cycle where the synced level agrees with the accepted one
    // restarts the count, so only an unbroken run is accepted.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        if (s != clean_q) begin
            if (cnt_q == TERM) begin
                clean_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            cnt_q   <= '0;
            clean_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= clean_d & ~clean_q;
            fall_q  <= ~clean_d & clean_q;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/car_input_conditioner.sv
// Conditions raw SW/KEY pins: synchronise, debounce, and derive edge pulses.
// Ports: clock, reset, sw_raw, key_raw -> sw_clean, key_clean, key_press, key_rel, sw_change.
module car_input_conditioner #(
    parameter int NUM_SW          = car_pkg::NUM_SW,
    parameter int NUM_KEY         = car_pkg::NUM_KEY,
    parameter int SYNC_STAGES     = car_pkg::SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = car_pkg::DEBOUNCE_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SW-1:0]  sw_raw,
    input  logic [NUM_KEY-1:0] key_raw,
    output logic [NUM_SW-1:0]  sw_clean,
    output logic [NUM_KEY-1:0] key_clean,
    output logic [NUM_KEY-1:0] key_press,
    output logic [NUM_KEY-1:0] key_rel,
    output logic               sw_change
);

    logic [NUM_SW-1:0] sw_rise;
    logic [NUM_SW-1:0] sw_fall;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (1'b0)
        ) u_db (
            .clock(clock),
            .reset(reset),
            .raw  (sw_raw[g]),
            .clean(sw_clean[g]),
            .rise (sw_rise[g]),
            .fall (sw_fall[g])
        );
    end

    // Keys idle released; a press is the clean level falling to KEY_PRESSED
    for (genvar g = 0; g < NUM_KEY; g++) begin : g_key
        debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (~car_pkg::KEY_PRESSED)
        ) u_db (
            .clock(clock),
            .reset(reset),
            .raw  (key_raw[g]),
            .clean(key_clean[g]),
            .rise (key_rel[g]),
            .fall (key_press[g])
        );
    end

    // OR of registered flags only, so no input-to-output path
    assign sw_change = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_car_input_conditioner.sv
// Bench for car_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Table vectors, directed corner sequences, and a per-cycle expected-output queue.
module tb_car_input_conditioner;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] sw_raw;
    logic [1:0] key_raw;
    logic [9:0] sw_clean;
    logic [1:0] key_clean;
    logic [1:0] key_press;
    logic [1:0] key_rel;
    logic       sw_change;

    always #5 clock = ~clock;

    car_input_conditioner #(
        .NUM_SW         (10),
        .NUM_KEY        (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .key_raw  (key_raw),
        .sw_clean (sw_clean),
        .key_clean(key_clean),
        .key_press(key_press),
        .key_rel  (key_rel),
        .sw_change(sw_change)
    );

    typedef struct packed {
        logic [9:0] sw;
        logic [1:0] key;
        logic [1:0] kp;
        logic [1:0] kr;
        logic       swc;
    } exp_t;

    typedef struct {
        logic [9:0] sw;
        logic [1:0] key;
        logic [9:0] exp_sw;
        logic [1:0] exp_key;
    } vec_t;

    localparam logic [11:0] RV = {2'b11, 10'b0};

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;

    // Reference: a bit flips once its last four synced samples all
    // disagree with the accepted level.
    logic [11:0] m_s1, m_s2, m_clean;
    logic [11:0] m_h[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [9:0] sw, input logic [1:0] key,
                        input logic rst);
        logic [11:0] flip;
        logic [11:0] rise;
        logic [11:0] fall;
        exp_t        e;
        exp_t        got;
        @(negedge clock);
        sw_raw  = sw;
        key_raw = key;
        reset   = rst;
        flip = '0;
        rise = '0;
        fall = '0;
        if (rst) begin
            m_s1 = RV;
            m_s2 = RV;
            m_clean = RV;
            for (int i = 0; i < 4; i++) m_h[i] = RV;
        end else begin
            m_h[3] = m_h[2];
            m_h[2] = m_h[1];
            m_h[1] = m_h[0];
            m_h[0] = m_s2;
            for (int i = 0; i < 12; i++)
                flip[i] = (m_h[0][i] != m_clean[i]) && (m_h[1][i] != m_clean[i])
                       && (m_h[2][i] != m_clean[i]) && (m_h[3][i] != m_clean[i]);
            m_clean = m_clean ^ flip;
            rise = flip & m_clean;
            fall = flip & ~m_clean;
            m_s2 = m_s1;
            m_s1 = {key, sw};
        end
        e.sw  = m_clean[9:0];
        e.key = m_clean[11:10];
        e.kp  = fall[11:10];
        e.kr  = rise[11:10];
        e.swc = |flip[9:0];
        q.push_back(e);
        @(posedge clock);
        #1;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            e = q.pop_front();
            got = {sw_clean, key_clean, key_press, key_rel, sw_change};
            chk("sb_sw_clean", 32'(got.sw), 32'(e.sw));
            chk("sb_key_clean", 32'(got.key), 32'(e.key));
            chk("sb_key_press", 32'(got.kp), 32'(e.kp));
            chk("sb_key_rel", 32'(got.kr), 32'(e.kr));
            chk("sb_sw_change", 32'(got.swc), 32'(e.swc));
        end
    endtask

    vec_t vecs[5];

    initial begin
        int first, n, at, n2, at2, nr, flag;
        logic [1:0] pat[5];

        vecs[0] = '{10'h155, 2'b10, 10'h155, 2'b10};
        vecs[1] = '{10'h2AA, 2'b01, 10'h2AA, 2'b01};
        vecs[2] = '{10'h3FF, 2'b00, 10'h3FF, 2'b00};
        vecs[3] = '{10'h001, 2'b11, 10'h001, 2'b11};
        vecs[4] = '{10'h000, 2'b11, 10'h000, 2'b11};

        sw_raw  = '0;
        key_raw = '1;
        reset   = 1'b0;

        // Reset with pins in their non-reset states
        for (int i = 0; i < 3; i++) step(10'h3FF, 2'b00, 1'b1);
        chk("rst_sw_clean", 32'(sw_clean), 32'h0);
        chk("rst_key_clean", 32'(key_clean), 32'h3);
        chk("rst_pulses", 32'({key_press, key_rel, sw_change}), 32'h0);

        for (int i = 0; i < 6; i++) step(10'h000, 2'b11, 1'b0);

        // Table vectors, each held long enough to settle
        foreach (vecs[v]) begin
            for (int i = 0; i < 8; i++) step(vecs[v].sw, vecs[v].key, 1'b0);
            chk("vec_sw_clean", 32'(sw_clean), 32'(vecs[v].exp_sw));
            chk("vec_key_clean", 32'(key_clean), 32'(vecs[v].exp_key));
        end

        // Latency: first sampled at k=0, visible after k=5
        first = -1; n = 0; at = -1;
        for (int k = 0; k < 9; k++) begin
            step(10'h008, 2'b11, 1'b0);
            if (sw_clean[3] && first < 0) first = k;
            if (sw_change) begin n++; at = k; end
        end
        chk("lat_first", 32'(first), 32'd5);
        chk("lat_chg_count", 32'(n), 32'd1);
        chk("lat_chg_at", 32'(at), 32'd5);

        // Glitch: three low samples on key 1 are rejected
        n = 0; flag = 0;
        for (int k = 0; k < 11; k++) begin
            step(10'h008, (k < 3) ? 2'b01 : 2'b11, 1'b0);
            if (key_press != 2'b00) n++;
            if (key_clean != 2'b11) flag = 1;
        end
        chk("glitch_press", 32'(n), 32'd0);
        chk("glitch_clean", 32'(flag), 32'd0);

        // Bounce on key 0, then held pressed
        pat[0] = 2'b10; pat[1] = 2'b11; pat[2] = 2'b10;
        pat[3] = 2'b11; pat[4] = 2'b10;
        n = 0; at = -1; nr = 0;
        for (int k = 0; k < 15; k++) begin
            step(10'h008, (k < 5) ? pat[k] : 2'b10, 1'b0);
            if (key_press[0]) begin n++; at = k; end
            if (key_rel != 2'b00) nr++;
        end
        chk("bounce_press_count", 32'(n), 32'd1);
        chk("bounce_press_at", 32'(at), 32'd9);
        chk("bounce_rel", 32'(nr), 32'd0);
        for (int k = 0; k < 8; k++) step(10'h008, 2'b11, 1'b0);
        chk("bounce_released", 32'(key_clean), 32'h3);

        for (int k = 0; k < 8; k++) step(10'h000, 2'b11, 1'b0);

        // Simultaneous: every bit changes on the same edge
        n = 0; n2 = 0; at = -1; at2 = -1;
        for (int k = 0; k < 8; k++) begin
            step(10'h3FF, 2'b00, 1'b0);
            if (k == 4) chk("sim_before", 32'({sw_clean, key_clean}), 32'h003);
            if (k == 5) begin
                chk("sim_sw_clean", 32'(sw_clean), 32'h3FF);
                chk("sim_key_clean", 32'(key_clean), 32'h0);
                chk("sim_key_press", 32'(key_press), 32'h3);
            end
            if (sw_change) begin n++; at = k; end
            if (key_press != 2'b00) begin n2++; at2 = k; end
        end
        chk("sim_chg_count", 32'(n), 32'd1);
        chk("sim_chg_at", 32'(at), 32'd5);
        chk("sim_press_count", 32'(n2), 32'd1);
        chk("sim_press_at", 32'(at2), 32'd5);

        for (int k = 0; k < 8; k++) step(10'h3FF, 2'b11, 1'b0);

        // Reset mid-count: key 0 pressed, reset when its counter is 2
        for (int k = 0; k < 4; k++) step(10'h3FF, 2'b10, 1'b0);
        step(10'h3FF, 2'b10, 1'b1);
        chk("midrst_key_clean", 32'(key_clean), 32'h3);
        chk("midrst_sw_clean", 32'(sw_clean), 32'h0);
        chk("midrst_pulses", 32'({key_press, key_rel, sw_change}), 32'h0);
        n = 0; at = -1;
        for (int k = 1; k < 10; k++) begin
            step(10'h3FF, 2'b10, 1'b0);
            if (key_press[0]) begin n++; at = k; end
        end
        chk("midrst_press_count", 32'(n), 32'd1);
        chk("midrst_press_at", 32'(at), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
